wb_write_arbiter: RTL and testbench

//  Drives the register file write port (W_w_ena/W_w_addr/W_w_data).
//  - Merges two write sources: the in-order pipeline writeback and the long-latency unit (mul/div).
//  - Formats load data by load type and byte offset.
//  - Keeps a per-register busy scoreboard so ID can stall on pending long-latency results.
//  - Sits between the MEM/WB pipeline register and the regfile.

---
 rtl/wb_write_arbiter.sv | 129 ++++++++++++
 tb/tb_wb_write_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter: merges pipeline writeback with long-latency results,
// formats load data, and tracks per-register pending long-latency writes for ID stalls.
module wb_write_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_valid,
  output logic        p_ready,
  input  logic [4:0]  p_addr,
  input  logic [31:0] p_data,
  input  logic        p_is_load,
  input  logic [2:0]  p_load_type,
  input  logic [1:0]  p_byte_off,
  input  logic        l_valid,
  output logic        l_ready,
  input  logic [4:0]  l_addr,
  input  logic [31:0] l_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic        rs_busy,
  output logic        rt_busy,
  output logic        stall_req,
  output logic        W_w_ena,
  output logic [4:0]  W_w_addr,
  output logic [31:0] W_w_data
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   busy_q, busy_d;
  logic          w_ena_q, w_ena_d;
  logic [4:0]    w_addr_q, w_addr_d;
  logic [31:0]   w_data_q, w_data_d;
  logic          p_acc, l_acc;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   p_fmt;

  // Handshake: a request is accepted on any rising edge where valid && ready;
  // ready is combinational and the source must hold its request until accepted.
  // The pipeline wins ties unless the long-latency source has waited STARVE_MAX cycles.
  always_comb begin
    stall_req = (cnt_q >= CW'(STARVE_MAX));
    p_ready   = !stall_req;
    l_ready   = l_valid && (!p_valid || stall_req);
    p_acc     = p_valid && p_ready;
    l_acc     = l_valid && l_ready;
  end

  always_comb begin
    cnt_d = '0;
    if (l_valid && !l_ready) begin
      cnt_d = (cnt_q >= CW'(STARVE_MAX)) ? cnt_q : cnt_q + CW'(1);
    end
  end

  // Little-endian lane select; halfword uses only byte_off[1].
  always_comb begin
    case (p_byte_off)
      2'd0:    ld_byte = p_data[7:0];
      2'd1:    ld_byte = p_data[15:8];
      2'd2:    ld_byte = p_data[23:16];
      default: ld_byte = p_data[31:24];
    endcase
    ld_half = p_byte_off[1] ? p_data[31:16] : p_data[15:0];
    p_fmt   = p_data;
    if (p_is_load) begin
      case (p_load_type)
        3'd1:    p_fmt = {{24{ld_byte[7]}}, ld_byte};
        3'd2:    p_fmt = {24'd0, ld_byte};
        3'd3:    p_fmt = {{16{ld_half[15]}}, ld_half};
        3'd4:    p_fmt = {16'd0, ld_half};
        default: p_fmt = p_data;
      endcase
    end
  end

  // Writes to $0 complete the handshake but never assert the enable.
  always_comb begin
    w_ena_d  = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    if (p_acc && p_addr != 5'd0) begin
      w_ena_d  = 1'b1;
      w_addr_d = p_addr;
      w_data_d = p_fmt;
    end else if (l_acc && l_addr != 5'd0) begin
      w_ena_d  = 1'b1;
      w_addr_d = l_addr;
      w_data_d = l_data;
    end
  end

  // Set after clear so a same-cycle issue to the retiring register stays busy.
  always_comb begin
    busy_d = busy_q;
    if (l_acc) busy_d[l_addr] = 1'b0;
    if (iss_valid && iss_addr != 5'd0) busy_d[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      busy_q   <= '0;
      w_ena_q  <= 1'b0;
      w_addr_q <= 5'd0;
      w_data_q <= 32'd0;
    end else begin
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      w_ena_q  <= w_ena_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  always_comb begin
    rs_busy  = busy_q[rs_addr] && (rs_addr != 5'd0);
    rt_busy  = busy_q[rt_addr] && (rt_addr != 5'd0);
    W_w_ena  = w_ena_q;
    W_w_addr = w_addr_q;
    W_w_data = w_data_q;
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: expected regfile writes go into a queue when the
// request is driven and are popped by a negedge monitor on the cycle they must appear.
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p_valid = 1'b0;
  logic        p_ready;
  logic [4:0]  p_addr = '0;
  logic [31:0] p_data = '0;
  logic        p_is_load = 1'b0;
  logic [2:0]  p_load_type = '0;
  logic [1:0]  p_byte_off = '0;
  logic        l_valid = 1'b0;
  logic        l_ready;
  logic [4:0]  l_addr = '0;
  logic [31:0] l_data = '0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_addr = '0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic        rs_busy, rt_busy, stall_req;
  logic        W_w_ena;
  logic [4:0]  W_w_addr;
  logic [31:0] W_w_data;

  int checks = 0;
  int errors = 0;
  logic        mon_en = 1'b0;
  logic [36:0] exp_q[$];
  logic        pend_v = 1'b0;
  logic [36:0] pend = '0;

  wb_write_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_ready(p_ready), .p_addr(p_addr), .p_data(p_data),
    .p_is_load(p_is_load), .p_load_type(p_load_type), .p_byte_off(p_byte_off),
    .l_valid(l_valid), .l_ready(l_ready), .l_addr(l_addr), .l_data(l_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .stall_req(stall_req),
    .W_w_ena(W_w_ena), .W_w_addr(W_w_addr), .W_w_data(W_w_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected write becomes due on the cycle after the coming edge.
  task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
    pend_v = 1'b1;
    pend   = {a, d};
  endtask

  task automatic tick();
    @(posedge clk);
    if (pend_v) exp_q.push_back(pend);
    pend_v = 1'b0;
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        chk("idle_ena", {31'd0, W_w_ena}, 32'd0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("wr_ena", {31'd0, W_w_ena}, 32'd1);
        chk("wr_addr", {27'd0, W_w_addr}, {27'd0, e[36:32]});
        chk("wr_data", W_w_data, e[31:0]);
      end
    end
  end

  task automatic do_load(input logic [4:0] a, input logic [2:0] t, input logic [1:0] off,
                         input logic ld, input logic [31:0] exp);
    p_valid = 1'b1; p_addr = a; p_data = 32'h80FF7F01;
    p_is_load = ld; p_load_type = t; p_byte_off = off;
    #1 chk("load_p_ready", {31'd0, p_ready}, 32'd1);
    expect_write(a, exp);
    tick();
  endtask

  initial begin
    // Reset
    tick(); tick();
    chk("rst_ena", {31'd0, W_w_ena}, 32'd0);
    chk("rst_addr", {27'd0, W_w_addr}, 32'd0);
    chk("rst_data", W_w_data, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    rs_addr = 5'd9; rt_addr = 5'd3; #1;
    chk("rst_rs_busy", {31'd0, rs_busy}, 32'd0);
    chk("rst_rt_busy", {31'd0, rt_busy}, 32'd0);
    rst = 1'b0;
    tick();
    mon_en = 1'b1;

    // Pipeline ALU write
    p_valid = 1'b1; p_addr = 5'd5; p_data = 32'h1234;
    #1 chk("alu_p_ready", {31'd0, p_ready}, 32'd1);
    chk("alu_l_ready", {31'd0, l_ready}, 32'd0);
    expect_write(5'd5, 32'h1234);
    tick();
    p_valid = 1'b0;
    tick();

    // Load formatting, back to back
    do_load(5'd1, 3'd1, 2'd3, 1'b1, 32'hFFFFFF80);
    do_load(5'd2, 3'd2, 2'd2, 1'b1, 32'h000000FF);
    do_load(5'd3, 3'd3, 2'd2, 1'b1, 32'hFFFF80FF);
    do_load(5'd4, 3'd4, 2'd0, 1'b1, 32'h00007F01);
    do_load(5'd11, 3'd1, 2'd1, 1'b1, 32'h0000007F);
    do_load(5'd12, 3'd3, 2'd3, 1'b1, 32'hFFFF80FF);
    do_load(5'd13, 3'd4, 2'd1, 1'b1, 32'h00007F01);
    do_load(5'd14, 3'd0, 2'd1, 1'b1, 32'h80FF7F01);
    do_load(5'd15, 3'd6, 2'd3, 1'b1, 32'h80FF7F01);
    do_load(5'd16, 3'd1, 2'd3, 1'b0, 32'h80FF7F01);
    p_valid = 1'b0; p_is_load = 1'b0;
    tick();

    // Contention: pipeline wins 4 cycles, then long-latency preempts
    p_valid = 1'b1; p_addr = 5'd6;
    l_valid = 1'b1; l_addr = 5'd7; l_data = 32'hBEEF;
    for (int i = 0; i < 4; i++) begin
      p_data = 32'hA0 + i;
      #1 chk("cont_l_ready", {31'd0, l_ready}, 32'd0);
      chk("cont_p_ready", {31'd0, p_ready}, 32'd1);
      chk("cont_stall", {31'd0, stall_req}, 32'd0);
      expect_write(5'd6, 32'hA0 + i);
      tick();
    end
    p_data = 32'hA4;
    #1 chk("pre_stall", {31'd0, stall_req}, 32'd1);
    chk("pre_p_ready", {31'd0, p_ready}, 32'd0);
    chk("pre_l_ready", {31'd0, l_ready}, 32'd1);
    expect_write(5'd7, 32'hBEEF);
    tick();
    l_valid = 1'b0;
    #1 chk("post_stall", {31'd0, stall_req}, 32'd0);
    chk("post_p_ready", {31'd0, p_ready}, 32'd1);
    expect_write(5'd6, 32'hA4);
    tick();
    p_valid = 1'b0;

    // Long-latency alone is accepted immediately
    l_valid = 1'b1; l_addr = 5'd8; l_data = 32'h88;
    #1 chk("lonly_l_ready", {31'd0, l_ready}, 32'd1);
    expect_write(5'd8, 32'h88);
    tick();
    l_valid = 1'b0;

    // Scoreboard set / clear
    iss_valid = 1'b1; iss_addr = 5'd9;
    tick();
    iss_valid = 1'b0;
    rs_addr = 5'd9; rt_addr = 5'd10;
    #1 chk("sb_rs_set", {31'd0, rs_busy}, 32'd1);
    chk("sb_rt_other", {31'd0, rt_busy}, 32'd0);
    rt_addr = 5'd9;
    #1 chk("sb_rt_set", {31'd0, rt_busy}, 32'd1);
    l_valid = 1'b1; l_addr = 5'd9; l_data = 32'h99;
    #1 chk("sb_l_ready", {31'd0, l_ready}, 32'd1);
    chk("sb_busy_before", {31'd0, rs_busy}, 32'd1);
    expect_write(5'd9, 32'h99);
    tick();
    l_valid = 1'b0;
    #1 chk("sb_rs_clear", {31'd0, rs_busy}, 32'd0);
    iss_valid = 1'b1;
    tick();
    l_valid = 1'b1; l_data = 32'h999;
    expect_write(5'd9, 32'h999);
    tick();
    l_valid = 1'b0; iss_valid = 1'b0;
    #1 chk("sb_set_wins", {31'd0, rs_busy}, 32'd1);
    l_valid = 1'b1; l_data = 32'h9999;
    expect_write(5'd9, 32'h9999);
    tick();
    l_valid = 1'b0;
    #1 chk("sb_final_clear", {31'd0, rs_busy}, 32'd0);

    // Pipeline writes leave busy alone
    iss_valid = 1'b1; iss_addr = 5'd20;
    tick();
    iss_valid = 1'b0;
    p_valid = 1'b1; p_addr = 5'd20; p_data = 32'h2020;
    expect_write(5'd20, 32'h2020);
    tick();
    p_valid = 1'b0; rs_addr = 5'd20;
    #1 chk("sb_p_no_clear", {31'd0, rs_busy}, 32'd1);

    // $0 writes
    p_valid = 1'b1; p_addr = 5'd0; p_data = 32'hDEAD;
    #1 chk("r0_p_ready", {31'd0, p_ready}, 32'd1);
    tick();
    p_valid = 1'b0;
    chk("r0_p_ena", {31'd0, W_w_ena}, 32'd0);
    l_valid = 1'b1; l_addr = 5'd0; l_data = 32'hDEAD;
    #1 chk("r0_l_ready", {31'd0, l_ready}, 32'd1);
    tick();
    l_valid = 1'b0;
    chk("r0_l_ena", {31'd0, W_w_ena}, 32'd0);
    iss_valid = 1'b1; iss_addr = 5'd0;
    tick();
    iss_valid = 1'b0; rs_addr = 5'd0;
    #1 chk("r0_no_busy", {31'd0, rs_busy}, 32'd0);

    // Reset mid-stream with starvation pending and busy[3] set
    iss_valid = 1'b1; iss_addr = 5'd3;
    tick();
    iss_valid = 1'b0; rs_addr = 5'd3;
    #1 chk("mr_busy3", {31'd0, rs_busy}, 32'd1);
    p_valid = 1'b1; p_addr = 5'd21; p_data = 32'h2121;
    l_valid = 1'b1; l_addr = 5'd3; l_data = 32'h3333;
    for (int i = 0; i < 4; i++) begin
      expect_write(5'd21, 32'h2121);
      tick();
    end
    chk("mr_stall_pre", {31'd0, stall_req}, 32'd1);
    rst = 1'b1;
    tick();
    chk("mr_ena", {31'd0, W_w_ena}, 32'd0);
    chk("mr_stall", {31'd0, stall_req}, 32'd0);
    chk("mr_busy_cleared", {31'd0, rs_busy}, 32'd0);
    p_valid = 1'b0; l_valid = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
